// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store, waits WAIT_CYCLES, then pulses a response.
// Optional macro DMEM_ALIGN_CHECK_EN rejects misaligned word/halfword accesses.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [32:0] ADDR_LO   = {1'b0, BASE_ADDR};
  localparam logic [32:0] ADDR_HI   = ADDR_LO + 33'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem_array [DEPTH_WORDS];

  logic             cur_we;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic [3:0]       cur_be;
  logic [31:0]      cur_offset;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_in_range;
  logic             cur_misaligned;
  logic             cur_err;
  logic             enter_resp;
  logic             mem_wr_en;

  // With zero wait states the request commits on its own accept edge, so decode the live inputs while idle.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
  end

  assign cur_offset   = cur_addr - BASE_ADDR;
  assign cur_idx      = IDX_W'(cur_offset >> 2);
  assign cur_in_range = ({1'b0, cur_addr} >= ADDR_LO) && ({1'b0, cur_addr} < ADDR_HI);

`ifdef DMEM_ALIGN_CHECK_EN
  assign cur_misaligned = ((cur_be == 4'b1111) && (cur_addr[1:0] != 2'b00)) ||
                          (((cur_be == 4'b0011) || (cur_be == 4'b1100)) && cur_addr[0]);
`else
  assign cur_misaligned = 1'b0;
`endif

  assign cur_err = !cur_in_range || cur_misaligned;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    enter_resp  = 1'b0;
    mem_wr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Read data and error are captured, and stores commit, on the edge that enters RESP.
    if ((state_q != ST_RESP) && (state_d == ST_RESP)) begin
      enter_resp  = 1'b1;
      rsp_err_d   = cur_err;
      rsp_rdata_d = (cur_err || cur_we) ? 32'h0 : mem_array[cur_idx];
      mem_wr_en   = cur_we && !cur_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array is never reset; a store caught by reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && mem_wr_en) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (cur_be[lane]) begin
          mem_array[cur_idx][8*lane +: 8] <= cur_wdata[8*lane +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written timing/reset sequences,
// and randomized traffic against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WAITC = 1;
  localparam longint unsigned BASE = 64'h1000;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid0, req_ready0, req_we0;
  logic [31:0] req_addr0, req_wdata0;
  logic [3:0]  req_be0;
  logic        rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [DEPTH];

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC), .BASE_ADDR(32'h0000_1000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1000)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0), .req_addr(req_addr0),
    .req_wdata(req_wdata0), .req_be(req_be0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: a request is a whole-word operation on a plain array, judged only by address range and lanes.
  function automatic void modelApply(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [3:0] be, output logic [31:0] rdata, output logic err);
    longint unsigned a = longint'(addr);
    int idx;
    err = !(a >= BASE && a < BASE + 4 * DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    if (be == 4'hF && addr[1:0] != 2'b00) err = 1'b1;
    if ((be == 4'h3 || be == 4'hC) && addr[0]) err = 1'b1;
`endif
    rdata = 32'h0;
    if (!err) begin
      idx = int'((a - BASE) / 4);
      if (we) begin
        for (int l = 0; l < 4; l++)
          if (be[l]) model_mem[idx][8*l +: 8] = wdata[8*l +: 8];
      end else begin
        rdata = model_mem[idx];
      end
    end
  endfunction

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, output int lat, output int ready_low,
                               output logic [31:0] rdata, output logic err, output logic extra_pulse,
                               output logic [31:0] held_rdata, output logic held_err);
    int n = 0;
    lat = 0; ready_low = 0; rdata = 'x; err = 'x; extra_pulse = 'x; held_rdata = 'x; held_err = 'x;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      checkOutput("accept_timeout", 32'(req_ready), 32'h1);
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      if (!req_ready) ready_low++;
      @(negedge clk);
      lat++;
    end
    if (!req_ready) ready_low++;
    rdata = rsp_rdata;
    err = rsp_err;
    @(negedge clk);
    extra_pulse = rsp_valid;
    held_rdata = rsp_rdata;
    held_err = rsp_err;
  endtask

  function automatic void addVec(input string name, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  initial begin
    int lat, rlow;
    logic [31:0] rd, hrd, mrd, old_val;
    logic er, her, extra, mer;
    logic [5:0] rdy_bits, rv_bits, err_bits;
    bit saw_rsp;

    rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0;
    req_valid0 = 0; req_we0 = 0; req_addr0 = 32'h0; req_wdata0 = 0; req_be0 = 4'hF;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 32'(req_ready), 32'h1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_err", 32'(rsp_err), 32'h0);
    rst_n = 1'b1;

    // Give every word a known value so later loads are predictable.
    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [31:0] fill = 32'h5A00_0000 | 32'(i);
      applyStimulus(1'b1, 32'h1000 + 32'(4 * i), fill, 4'hF, lat, rlow, rd, er, extra, hrd, her);
      modelApply(1'b1, 32'h1000 + 32'(4 * i), fill, 4'hF, mrd, mer);
      if (i % 64 == 0) checkOutput("fill_err", 32'(er), 32'h0);
    end

    addVec("st_1000",        1, 32'h1000, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    addVec("ld_1000",        0, 32'h1000, 32'h0,        4'hF, 32'hDEADBEEF, 0);
    addVec("st_1004",        1, 32'h1004, 32'h11223344, 4'hF, 32'h0, 0);
    addVec("st_1004_lane1",  1, 32'h1004, 32'h0000AB00, 4'b0010, 32'h0, 0);
    addVec("ld_1004",        0, 32'h1004, 32'h0,        4'b0000, 32'h1122AB44, 0);
    addVec("st_13fc",        1, 32'h13FC, 32'hAAAA5555, 4'hF, 32'h0, 0);
    addVec("ld_0ffc_oor",    0, 32'h0FFC, 32'h0,        4'hF, 32'h0, 1);
    addVec("st_1400_oor",    1, 32'h1400, 32'h12345678, 4'hF, 32'h0, 1);
    addVec("ld_13fc",        0, 32'h13FC, 32'h0,        4'hF, 32'hAAAA5555, 0);
    addVec("st_1008",        1, 32'h1008, 32'h01020304, 4'hF, 32'h0, 0);
    addVec("st_1008_be0",    1, 32'h1008, 32'hFFFFFFFF, 4'h0, 32'h0, 0);
    addVec("ld_1008",        0, 32'h1008, 32'h0,        4'hF, 32'h01020304, 0);
    addVec("ld_ffff_fffc",   0, 32'hFFFF_FFFC, 32'h0,   4'hF, 32'h0, 1);
`ifdef DMEM_ALIGN_CHECK_EN
    addVec("st_1002_word",   1, 32'h1002, 32'h55667788, 4'hF, 32'h0, 1);
    addVec("ld_1000_after",  0, 32'h1000, 32'h0,        4'hF, 32'hDEADBEEF, 0);
    addVec("st_1005_half",   1, 32'h1005, 32'h0000FFFF, 4'b0011, 32'h0, 1);
    addVec("ld_1004_after",  0, 32'h1004, 32'h0,        4'hF, 32'h1122AB44, 0);
`else
    addVec("st_1002_word",   1, 32'h1002, 32'h55667788, 4'hF, 32'h0, 0);
    addVec("ld_1000_after",  0, 32'h1000, 32'h0,        4'hF, 32'h55667788, 0);
    addVec("st_1005_half",   1, 32'h1005, 32'h0000FFFF, 4'b0011, 32'h0, 0);
    addVec("ld_1004_after",  0, 32'h1004, 32'h0,        4'hF, 32'h1122FFFF, 0);
`endif

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].be, lat, rlow, rd, er, extra, hrd, her);
      modelApply(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].be, mrd, mer);
      checkOutput({vecs[k].name, "_rdata"}, rd, vecs[k].exp_rdata);
      checkOutput({vecs[k].name, "_err"}, 32'(er), 32'(vecs[k].exp_err));
      checkOutput({vecs[k].name, "_latency"}, 32'(lat), 32'(WAITC + 1));
      checkOutput({vecs[k].name, "_ready_low"}, 32'(rlow), 32'(WAITC + 1));
      checkOutput({vecs[k].name, "_pulse_width"}, 32'(extra), 32'h0);
      checkOutput({vecs[k].name, "_held_rdata"}, hrd, vecs[k].exp_rdata);
      checkOutput({vecs[k].name, "_held_err"}, 32'(her), 32'(vecs[k].exp_err));
    end

    // Zero-wait instance with valid held high: accept, respond, accept, respond...
    @(negedge clk);
    req_valid0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rdy_bits[i] = req_ready0;
      rv_bits[i]  = rsp_valid0;
      err_bits[i] = rsp_err0;
      @(negedge clk);
    end
    req_valid0 = 1'b0;
    checkOutput("w0_ready_pattern", 32'(rdy_bits), 32'(6'b010101));
    checkOutput("w0_rsp_pattern", 32'(rv_bits), 32'(6'b101010));
    checkOutput("w0_err_on_rsp", 32'(err_bits & rv_bits), 32'(6'b101010));

    // Reset while a store waits: no response, store dropped, ready right after release.
    old_val = model_mem[2];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1008; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    checkOutput("mr_ready_before", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    saw_rsp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    rst_n = 1'b1;
    checkOutput("mr_no_rsp", 32'(saw_rsp), 32'h0);
    checkOutput("mr_ready_after", 32'(req_ready), 32'h1);
    checkOutput("mr_rdata_cleared", rsp_rdata, 32'h0);
    applyStimulus(1'b0, 32'h1008, 32'h0, 4'hF, lat, rlow, rd, er, extra, hrd, her);
    checkOutput("mr_old_value", rd, old_val);
    checkOutput("mr_old_err", 32'(er), 32'h0);

    for (int i = 0; i < 80; i++) begin
      logic        we = 1'($urandom);
      logic [31:0] addr;
      logic [31:0] wdata = $urandom;
      logic [3:0]  be = 4'($urandom);
      case ($urandom_range(0, 7))
        0: addr = 32'h0000_0FFC;
        1: addr = 32'h0000_1400;
        2: addr = 32'hFFFF_FFFC;
        3: addr = $urandom;
        default: addr = 32'h1000 + 32'($urandom_range(0, 1023));
      endcase
      applyStimulus(we, addr, wdata, be, lat, rlow, rd, er, extra, hrd, her);
      modelApply(we, addr, wdata, be, mrd, mer);
      checkOutput("rnd_rdata", rd, mrd);
      checkOutput("rnd_err", 32'(er), 32'(mer));
      checkOutput("rnd_latency", 32'(lat), 32'(WAITC + 1));
    end

    // Read back a spread of words so random stores are observed.
    for (int i = 0; i < int'(DEPTH); i += 17) begin
      applyStimulus(1'b0, 32'h1000 + 32'(4 * i), 32'h0, 4'h0, lat, rlow, rd, er, extra, hrd, her);
      modelApply(1'b0, 32'h1000 + 32'(4 * i), 32'h0, 4'h0, mrd, mer);
      checkOutput("sweep_rdata", rd, mrd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Synthesizable data-memory target for the riscv_top MEM stage. It is the responder end of the core's load/store request interface.
- Accepts one request per handshake and holds it through a configurable number of wait states.
- Performs a byte-lane-masked write or a word read on an internal array, then returns a single-cycle response with read data and an error flag.
- Used in simulation to stress pipeline stall logic with non-zero memory latency.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; power of two, minimum 4.
- WAIT_CYCLES, 1, idle cycles inserted between acceptance and response; range 0..15.
- BASE_ADDR, 32'h0000_1000, byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, already lane-positioned.
- req_be  input  4  byte-lane enables; bit i selects wdata[8i+7:8i].
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load data; zero on stores and on errors.
- rsp_err  output  1  request rejected; valid only with rsp_valid.

Behaviour:
- Reset, sampled on the clk edge while rst_n=0:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Array contents are not reset.
- Reset asserted mid-transaction aborts it: no response is issued, and a pending store is not written.
- FSM IDLE:
  - req_ready=1.
  - On req_valid & req_ready, latch we, addr, wdata and be.
  - Go to WAIT with counter=WAIT_CYCLES-1, or go directly to RESP if WAIT_CYCLES=0.
- FSM WAIT:
  - req_ready=0.
  - Decrement the counter each cycle; go to RESP on the cycle the counter is 0.
- FSM RESP:
  - req_ready=0, rsp_valid=1 for exactly one cycle, then return to IDLE.
- Latency and throughput:
  - rsp_valid is high exactly WAIT_CYCLES+1 cycles after the accept edge.
  - Maximum throughput is one request per WAIT_CYCLES+2 cycles.
- Address decode:
  - Offset = req_addr - BASE_ADDR; word index = offset[log2(DEPTH_WORDS)+1:2].
  - A request is in range when BASE_ADDR <= req_addr < BASE_ADDR + 4*DEPTH_WORDS. Compare with 33-bit arithmetic so the top of the address space does not wrap.
- Store:
  - The write commits on the clock edge that enters RESP, and only to lanes where be=1.
  - be=4'b0000 is legal and writes nothing; the response is still issued with err=0.
- Load:
  - rsp_rdata is the full word at the index read when entering RESP; be is ignored.
- Error:
  - An out-of-range request gives rsp_err=1 and rsp_rdata=0, and no write occurs.
- Protocol:
  - req_valid while req_ready=0 is ignored; the core holds the request until accepted.
  - Request inputs may change freely after acceptance.
- Back-to-back:
  - The RESP cycle never accepts; the next accept occurs in IDLE at the earliest one cycle after rsp_valid.
- Outputs rsp_rdata and rsp_err hold their last value while rsp_valid=0.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: a request also errors (rsp_err=1, no write, rdata=0) in either case:
  - be is 4'b1111 and req_addr[1:0]!=0;
  - be is 4'b0011 or 4'b1100 and req_addr[0]!=0.
- Undefined: req_addr[1:0] is ignored for indexing and checking; only be selects lanes.

Test Plan:
1. Reset, then store addr=0x1000, wdata=0xDEADBEEF, be=4'hF, WAIT_CYCLES=1 -> req_ready low 2 cycles, rsp_valid pulse 2 cycles after accept, err=0. Load from 0x1000 -> rdata=0xDEADBEEF.
2. Partial store addr=0x1004, wdata=0x0000AB00, be=4'b0010 over prior 0x11223344 -> load returns 0x1122AB44.
3. Out of range: load addr=0x0FFC and store addr=0x1400 (DEPTH_WORDS=256) -> rsp_err=1, rdata=0; a subsequent load of 0x13FC is unchanged.
4. WAIT_CYCLES=0 build, three back-to-back loads with req_valid held high -> accepts every 2nd cycle, rsp_valid exactly 1 cycle after each accept.
5. Reset mid-operation: accept a store to 0x1008 with 0xCAFEF00D, assert rst_n=0 in WAIT -> no rsp_valid. After release, load 0x1008 returns the old value and req_ready=1 on the first cycle after reset.
6. With DMEM_ALIGN_CHECK_EN: store addr=0x1002, be=4'hF -> rsp_err=1, memory unchanged. Without the macro, the same request writes word 0x1000 with err=0.
